// File: rtl/wimpfi_uart_pkg.sv
// Shared UART types and defaults for the wimpfi serial blocks.
package wimpfi_uart_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} rx_state_t;

   localparam int DATA_BITS     = 8;
   localparam int DEF_BAUD_RATE = 9600;
   localparam int DEF_CLKFREQ   = 100_000_000;
endpackage

// File: rtl/rate_enb.sv
// Free-running rate enable: one-cycle enb every CLKFREQ/RATE_HZ clocks.
module rate_enb #(
   parameter int RATE_HZ = 9600,
   parameter int CLKFREQ = 100_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic enb
);
   localparam int DIVAMT = CLKFREQ / RATE_HZ;
   localparam int DW     = (DIVAMT > 1) ? $clog2(DIVAMT) : 1;
   localparam logic [DW-1:0] LAST = DW'(DIVAMT - 1);

   logic [DW-1:0] q;

   always_ff @(posedge clk) begin
      if (rst || clr)
         q <= '0;
      else if (q == LAST)
         q <= '0;
      else
         q <= q + DW'(1);
   end

   assign enb = (q == LAST);
endmodule

// File: rtl/uart_rcvr.sv
// 8N1 serial receiver, oversampled on a free-running tick; reports framing errors and breaks.
module uart_rcvr
   import wimpfi_uart_pkg::*;
#(
   parameter int BAUD_RATE  = DEF_BAUD_RATE,
   parameter int CLKFREQ    = DEF_CLKFREQ,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] data,
   output logic                 rdy,
   output logic                 ferr
);
   localparam int TW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

   logic                 rx_meta, rxs;
   logic                 tick;
   rx_state_t            state;
   logic [TW-1:0]        tcnt;
   logic [2:0]           bcnt;
   logic [DATA_BITS-1:0] sr;

   rate_enb #(
      .RATE_HZ(BAUD_RATE * OVERSAMPLE),
      .CLKFREQ(CLKFREQ)
   ) u_tick (
      .clk(clk),
      .rst(rst),
      .clr(1'b0),
      .enb(tick)
   );

   // Idle-high synchronizer so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rxd;
         rxs     <= rx_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         tcnt  <= '0;
         bcnt  <= '0;
         sr    <= '0;
         data  <= '0;
         rdy   <= 1'b0;
         ferr  <= 1'b0;
      end else begin
         rdy  <= 1'b0;
         ferr <= 1'b0;
         if (tick) begin
            case (state)
               IDLE: begin
                  if (!rxs) begin
                     state <= START;
                     tcnt  <= '0;
                  end
               end
               START: begin
                  if (tcnt == T_MID) begin
                     tcnt  <= '0;
                     bcnt  <= '0;
                     state <= rxs ? IDLE : DATA;
                  end else
                     tcnt <= tcnt + TW'(1);
               end
               DATA: begin
                  if (tcnt == T_LAST) begin
                     tcnt <= '0;
                     sr   <= {rxs, sr[DATA_BITS-1:1]};
                     bcnt <= bcnt + 3'd1;
                     if (bcnt == 3'd7)
                        state <= STOP;
                  end else
                     tcnt <= tcnt + TW'(1);
               end
               STOP: begin
                  // Leaving at mid-stop leaves half a bit to catch a back-to-back start.
                  if (tcnt == T_LAST) begin
                     tcnt <= '0;
                     if (rxs) begin
                        data  <= sr;
                        rdy   <= 1'b1;
                        state <= IDLE;
                     end else begin
                        ferr  <= 1'b1;
                        state <= BRK;
                     end
                  end else
                     tcnt <= tcnt + TW'(1);
               end
               BRK: begin
                  if (rxs) begin
                     state <= IDLE;
                     tcnt  <= '0;
                  end
               end
               default: begin
                  state <= IDLE;
                  tcnt  <= '0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_rcvr.sv
// Self-checking bench for uart_rcvr: vector table, hand-built corner sequences, random frames.
module tb_uart_rcvr;
   import wimpfi_uart_pkg::*;

   localparam int BAUD = 9600;
   localparam int CLKF = 614_400;
   localparam int OS   = 16;
   localparam int DIV  = CLKF / (BAUD * OS);
   localparam int BITC = DIV * OS;
   localparam int LAT_LO = BITC * 19 / 2 - 4;
   localparam int LAT_HI = BITC * 19 / 2 + 14;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rxd = 1'b1;
   logic [7:0] data;
   logic       rdy, ferr;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [7:0] rx_q[$];
   int         rx_cyc_q[$];
   int         ferr_q[$];
   logic       prev_rdy = 1'b0, prev_ferr = 1'b0;

   typedef struct {
      logic [7:0] val;
      int         bc;
      logic       stop;
      int         exp_rdy;
      int         exp_ferr;
      logic [7:0] exp_data;
   } vec_t;

   vec_t tbl[7];

   always #5 clk = ~clk;

   uart_rcvr #(.BAUD_RATE(BAUD), .CLKFREQ(CLKF), .OVERSAMPLE(OS)) dut (
      .clk(clk),
      .rst(rst),
      .rxd(rxd),
      .data(data),
      .rdy(rdy),
      .ferr(ferr)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_rng(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         if (rdy) begin
            rx_q.push_back(data);
            rx_cyc_q.push_back(cyc);
         end
         if (ferr) ferr_q.push_back(cyc);
         if (rdy || ferr) begin
            chk("rdy_ferr_exclusive", {31'd0, rdy && ferr}, 32'd0);
            chk("single_cycle_pulse", {31'd0, (rdy && prev_rdy) || (ferr && prev_ferr)}, 32'd0);
         end
      end
      prev_rdy  = rdy;
      prev_ferr = ferr;
   end

   task automatic drive_bit(input logic b, input int n);
      rxd = b;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      drive_bit(1'b1, n);
   endtask

   task automatic send_frame(input logic [7:0] v, input logic stop, input int bc, output int edge_cyc);
      edge_cyc = cyc;
      drive_bit(1'b0, bc);
      for (int i = 0; i < 8; i++) drive_bit(v[i], bc);
      drive_bit(stop, bc);
      rxd = 1'b1;
   endtask

   task automatic clear_q();
      rx_q.delete();
      rx_cyc_q.delete();
      ferr_q.delete();
   endtask

   initial begin
      int e1, e2;
      logic [7:0] exp_d;

      tbl[0] = '{8'h55, BITC,     1'b1, 1, 0, 8'h55};
      tbl[1] = '{8'hE7, BITC - 2, 1'b1, 1, 0, 8'hE7};
      tbl[2] = '{8'hE7, BITC + 2, 1'b1, 1, 0, 8'hE7};
      tbl[3] = '{8'h00, BITC,     1'b1, 1, 0, 8'h00};
      tbl[4] = '{8'hFF, BITC,     1'b1, 1, 0, 8'hFF};
      tbl[5] = '{8'h12, BITC,     1'b0, 0, 1, 8'hFF};
      tbl[6] = '{8'h3C, BITC - 1, 1'b1, 1, 0, 8'h3C};

      // reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_data", {24'd0, data}, 32'h00);
      chk("reset_rdy", {31'd0, rdy}, 32'd0);
      chk("reset_ferr", {31'd0, ferr}, 32'd0);
      chk("reset_state", {29'd0, dut.state}, {29'd0, IDLE});
      rst = 1'b0;
      idle(2 * BITC);

      for (int i = 0; i < 7; i++) begin
         clear_q();
         send_frame(tbl[i].val, tbl[i].stop, tbl[i].bc, e1);
         idle(2 * BITC);
         chk($sformatf("tbl%0d_rdy_count", i), rx_q.size(), tbl[i].exp_rdy);
         chk($sformatf("tbl%0d_ferr_count", i), ferr_q.size(), tbl[i].exp_ferr);
         chk($sformatf("tbl%0d_data", i), {24'd0, data}, {24'd0, tbl[i].exp_data});
         if (rx_q.size() == 1)
            chk_rng($sformatf("tbl%0d_latency", i), rx_cyc_q[0] - e1, LAT_LO, LAT_HI);
      end

      // back-to-back frames with no idle gap
      clear_q();
      send_frame(8'hA3, 1'b1, BITC, e1);
      send_frame(8'h0F, 1'b1, BITC, e2);
      idle(2 * BITC);
      chk("b2b_rdy_count", rx_q.size(), 2);
      if (rx_q.size() == 2) begin
         chk("b2b_first", {24'd0, rx_q[0]}, 32'hA3);
         chk("b2b_second", {24'd0, rx_q[1]}, 32'h0F);
         chk_rng("b2b_spacing", rx_cyc_q[1] - rx_cyc_q[0], 10 * BITC - 8, 10 * BITC + 8);
      end

      // short low glitch is rejected at mid-start
      clear_q();
      drive_bit(1'b0, 4 * DIV);
      idle(2 * BITC);
      chk("glitch_rdy", rx_q.size(), 0);
      chk("glitch_ferr", ferr_q.size(), 0);
      chk("glitch_state", {29'd0, dut.state}, {29'd0, IDLE});
      send_frame(8'h3C, 1'b1, BITC, e1);
      idle(2 * BITC);
      chk("post_glitch_rdy", rx_q.size(), 1);
      chk("post_glitch_data", {24'd0, data}, 32'h3C);

      // framing error followed by a held-low break
      send_frame(8'h55, 1'b1, BITC, e1);
      idle(BITC);
      clear_q();
      drive_bit(1'b0, BITC);
      for (int i = 0; i < 8; i++) drive_bit(1'(8'h81 >> i), BITC);
      drive_bit(1'b0, 2 * BITC);
      chk("brk_state", {29'd0, dut.state}, {29'd0, BRK});
      drive_bit(1'b0, BITC);
      idle(2 * BITC);
      chk("brk_ferr_count", ferr_q.size(), 1);
      chk("brk_rdy_count", rx_q.size(), 0);
      chk("brk_data_held", {24'd0, data}, 32'h55);
      chk("brk_exit_state", {29'd0, dut.state}, {29'd0, IDLE});
      send_frame(8'h7E, 1'b1, BITC, e1);
      idle(2 * BITC);
      chk("post_brk_rdy", rx_q.size(), 1);
      chk("post_brk_data", {24'd0, data}, 32'h7E);

      // reset in the middle of bit 4 aborts the frame
      clear_q();
      drive_bit(1'b0, BITC);
      for (int i = 0; i < 4; i++) drive_bit(1'b0, BITC);
      drive_bit(1'b1, BITC / 2);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(3 * BITC);
      chk("abort_rdy", rx_q.size(), 0);
      chk("abort_ferr", ferr_q.size(), 0);
      chk("abort_data", {24'd0, data}, 32'h00);
      chk("abort_state", {29'd0, dut.state}, {29'd0, IDLE});
      send_frame(8'hC6, 1'b1, BITC, e1);
      idle(2 * BITC);
      chk("post_abort_rdy", rx_q.size(), 1);
      chk("post_abort_data", {24'd0, data}, 32'hC6);

      // random frames with bit-rate skew and occasional bad stop bits
      exp_d = 8'hC6;
      for (int n = 0; n < 40; n++) begin
         logic [7:0] v;
         int bc;
         logic good;
         v    = 8'($urandom_range(0, 255));
         bc   = $urandom_range(BITC - 2, BITC + 2);
         good = ($urandom_range(0, 7) != 0);
         clear_q();
         send_frame(v, good, bc, e1);
         idle(4 * DIV);
         if (good) exp_d = v;
         chk($sformatf("rnd%0d_rdy_count", n), rx_q.size(), good ? 1 : 0);
         chk($sformatf("rnd%0d_ferr_count", n), ferr_q.size(), good ? 0 : 1);
         chk($sformatf("rnd%0d_data", n), {24'd0, data}, {24'd0, exp_d});
         idle($urandom_range(0, BITC));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_rcvr.md
# uart_rcvr

Asynchronous serial receiver for 8N1 frames (1 start, 8 data LSB-first, 1 stop). It sits on the host-facing serial port, opposite the baud-rate-enable-driven transmitter, and delivers received bytes to the network logic with a one-cycle ready pulse. Bit timing comes from an internal oversampling clock enable, so all flops stay on the single system clock. Framing errors and line breaks are detected and reported, not delivered as data.

## Interface
- BAUD_RATE, 9600: serial bit rate in Hz.
- CLKFREQ, 100_000_000: clk frequency in Hz.
- OVERSAMPLE, 16: sample ticks per bit; must be even and at least 8.
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-high.
- rxd  input  1  asynchronous serial line, idle high.
- data  output  8  last good received byte; held until the next good frame.
- rdy  output  1  one-cycle pulse; `data` is valid on the same cycle.
- ferr  output  1  one-cycle pulse when the stop bit samples low.

## Operation
- `rxd` passes through a 2-flop synchronizer. Both flops reset to 1. All decisions below use the synchronized value `rxs`.
- Sample tick `tick` is a one-cycle enable with period DIVAMT = CLKFREQ/(BAUD_RATE*OVERSAMPLE), using integer truncation.
  - Defaults give 651 clocks per tick and 10416 clocks per bit.
  - The tick generator runs freely and is not re-phased.
- Tick counter `tcnt` has $clog2(OVERSAMPLE) bits. Bit counter `bcnt` has 3 bits. Shift register `sr` has 8 bits and shifts right, taking the new bit into the MSB.
- Every state transition clears `tcnt`. All counting happens only on `tick`.
- The state machine has five states:
  - IDLE: on a tick with rxs=0, go to START.
  - START: on the tick where tcnt reaches OVERSAMPLE/2-1 (the mid-bit point), re-check the line.
    - rxs=0: go to DATA with bcnt=0.
    - rxs=1: treat as a glitch and return to IDLE. No output is produced.
  - DATA: on the tick where tcnt reaches OVERSAMPLE-1, shift rxs into `sr` and increment bcnt.
    - After the sample with bcnt=7, go to STOP.
  - STOP: on the tick where tcnt reaches OVERSAMPLE-1, sample the stop bit.
    - rxs=1: `data`<=`sr`, pulse `rdy`, go to IDLE.
    - rxs=0: pulse `ferr`, leave `data` unchanged, go to BRK.
  - BRK: wait for a tick with rxs=1, then go to IDLE. While in BRK, low line time never starts a new frame.
- `rdy` and `ferr` are never asserted together. Each is high for exactly one clk.
- Reset mid-frame aborts the frame: state returns to IDLE, all counters clear, and no pulse is produced.

## Timing
- Reset values:
  - data=8'h00, rdy=0, ferr=0, state=IDLE, sr=0, counters=0.
  - Tick generator counter=0; synchronizer flops=1.
- Input latency: a change on `rxd` reaches `rxs` 2 clocks later.
- Start detection: the start edge is detected within 1 tick of its arrival.
- Sampling points: each data-bit sample falls at about the bit centre (±1 tick), i.e. 1.5, 2.5 … 8.5 bit periods after the detected start tick.
- Output timing: `rdy`/`ferr` assert on the clk after the stop-sample tick, registered from the state machine.
  - Total latency from the start edge to `rdy` is about 9.5 bit periods (about 98 950 clocks at the defaults).
- Back-to-back frames: a start bit immediately following a good stop bit must be accepted. The receiver returns to IDLE at mid-stop, giving half a bit of margin.

## Structure
- Shared package `wimpfi_uart_pkg`:
  - enum `rx_state_t` {IDLE, START, DATA, STOP, BRK};
  - localparams DATA_BITS=8 and default BAUD_RATE/CLKFREQ.
- Sub-module: the existing parameterized rate-enable generator, instantiated with RATE_HZ=BAUD_RATE*OVERSAMPLE and clr tied low. No new divider logic is written.
- Synchronizer, state machine, counters and shift register are inline in uart_rcvr.

## Test plan
- Send frame 0x55 at 9600 baud after reset -> exactly one `rdy` pulse about 98 950 clocks after the start edge, with data=8'h55 and no `ferr`.
- Send 0xA3 followed immediately by 0x0F with no idle gap -> two `rdy` pulses about 10 bit periods apart, data=8'hA3 then 8'h0F.
- Pulse `rxd` low for 4 ticks (2604 clocks), then high -> no `rdy`, no `ferr`, state back in IDLE; a following 0x3C frame is received correctly.
- Send 0x81 with the stop bit forced low and the line held low for 3 bit periods, then high, then frame 0x7E -> one `ferr` pulse with data still 8'h55 (the previous value), no frame started during the low period, then `rdy` with data=8'h7E.
- Assert rst for 1 clk during bit 4 of a frame, then send 0xC6 -> no pulse from the aborted frame; data reads 8'h00 after reset and 8'hC6 after the new frame.
- Skew the transmitter bit rate by ±3% and send 0xE7 -> data=8'hE7 with no `ferr`.
